updown_seq_ctrl: RTL and testbench

//   Command sequencer for the 4-bit up/down counter datapath.
//   - Accepts LOAD / RUN-UP / RUN-DOWN commands over a valid/ready handshake.
//   - Drives the counter's load, enable and direction strobes; watches the count fed back.
//   - Runs N-step sequences, with optional saturation at the range limits and abort.
//   - Reports done, saturated and aborted status to the host logic.

---
 rtl/updown_seq_ctrl_if.sv | 40 ++++
 rtl/updown_seq_ctrl.sv | 110 +++++++++++
 tb/tb_updown_seq_ctrl.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/updown_seq_ctrl_if.sv
// Command/status bundle between the host logic, the up/down sequencer and
// the 4-bit counter datapath.
//   slave  : the sequencer (updown_seq_ctrl) side
//   master : the host + counter side
// Signals: cmd_valid/cmd_ready/cmd_op/cmd_arg command handshake, wrap_en and
// abort controls, cnt_value feedback, cnt_load/cnt_load_val/cnt_en/cnt_dir
// counter strobes, busy/done/sat/aborted/steps_left status.
interface updown_seq_ctrl_if #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [STEP_W-1:0] cmd_arg;
    logic              wrap_en;
    logic              abort;
    logic [WIDTH-1:0]  cnt_value;
    logic              cnt_load;
    logic [WIDTH-1:0]  cnt_load_val;
    logic              cnt_en;
    logic              cnt_dir;
    logic              busy;
    logic              done;
    logic              sat;
    logic              aborted;
    logic [STEP_W-1:0] steps_left;

    modport slave (
        input  cmd_valid, cmd_op, cmd_arg, wrap_en, abort, cnt_value,
        output cmd_ready, cnt_load, cnt_load_val, cnt_en, cnt_dir,
               busy, done, sat, aborted, steps_left
    );

    modport master (
        output cmd_valid, cmd_op, cmd_arg, wrap_en, abort, cnt_value,
        input  cmd_ready, cnt_load, cnt_load_val, cnt_en, cnt_dir,
               busy, done, sat, aborted, steps_left
    );
endinterface

// File: rtl/updown_seq_ctrl.sv
// Command sequencer for the up/down counter datapath. Accepts LOAD / UP /
// DOWN / NOP commands over a valid/ready handshake, strobes the counter and
// runs N-step sequences with optional saturation at the range limits.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : updown_seq_ctrl_if.slave (command, counter strobes, status)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a command, cmd_ready = 1
// LOAD  | one-cycle load strobe to the counter
// RUN   | one count step per cycle until N steps, a limit or abort
// DONE  | one-cycle done pulse, then back to IDLE
module updown_seq_ctrl #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 8
) (
    input logic            clk,
    input logic            reset,
    updown_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;

    state_t            state, state_nx;
    logic              dir_q;
    logic [WIDTH-1:0]  load_val_q;
    logic [STEP_W-1:0] steps_q;
    logic              sat_q;
    logic              aborted_q;

    logic accept;
    logic at_lim;
    logic sat_hit;
    logic en;

    assign accept  = bus.cmd_valid && (state == IDLE);
    assign at_lim  = dir_q ? (bus.cnt_value == '1) : (bus.cnt_value == '0);
    assign sat_hit = at_lim && !bus.wrap_en;
    assign en      = (state == RUN) && !bus.abort && !sat_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            dir_q      <= 1'b0;
            load_val_q <= '0;
            steps_q    <= '0;
            sat_q      <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                sat_q     <= 1'b0;
                aborted_q <= 1'b0;
                dir_q     <= (bus.cmd_op == OP_UP);
                steps_q   <= bus.cmd_arg;
                // Only a LOAD changes the load value; it is held otherwise.
                if (bus.cmd_op == OP_LOAD)
                    load_val_q <= bus.cmd_arg[WIDTH-1:0];
            end
            if ((state == LOAD || state == RUN) && bus.abort)
                aborted_q <= 1'b1;
            if (state == RUN && !bus.abort && sat_hit)
                sat_q <= 1'b1;
            if (en)
                steps_q <= steps_q - STEP_W'(1);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (bus.cmd_op)
                        OP_LOAD: state_nx = LOAD;
                        OP_UP, OP_DOWN:
                            state_nx = (bus.cmd_arg != '0) ? RUN : DONE;
                        default: state_nx = DONE;
                    endcase
                end
            end
            LOAD: state_nx = DONE;
            RUN: begin
                // Abort outranks saturation and the final step.
                if (bus.abort || sat_hit || steps_q == STEP_W'(1))
                    state_nx = DONE;
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready    = (state == IDLE);
        bus.busy         = (state != IDLE);
        bus.done         = (state == DONE);
        bus.cnt_load     = (state == LOAD) && !bus.abort;
        bus.cnt_load_val = load_val_q;
        bus.cnt_en       = en;
        bus.cnt_dir      = dir_q;
        bus.sat          = sat_q;
        bus.aborted      = aborted_q;
        bus.steps_left   = steps_q;
    end
endmodule

// File: tb/tb_updown_seq_ctrl.sv
module tb_updown_seq_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_checks = 0;
    int n_fail = 0;

    updown_seq_ctrl_if #(.WIDTH(4), .STEP_W(8)) bus ();

    updown_seq_ctrl #(.WIDTH(4), .STEP_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural up/down counter driven by the controller strobes.
    logic [3:0] cnt = 4'd0;
    always @(posedge clk) begin
        if (bus.cnt_load)
            cnt <= bus.cnt_load_val;
        else if (bus.cnt_en)
            cnt <= bus.cnt_dir ? cnt + 4'd1 : cnt - 4'd1;
    end
    assign bus.cnt_value = cnt;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;

    // Present a command at a negedge once ready; returns at the negedge of
    // the first cycle after acceptance.
    task automatic issue(input logic [1:0] op, input logic [7:0] arg, input logic wr);
        int t = 0;
        while (!bus.cmd_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (bus.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_ready: cmd_ready=%0b required 1", bus.cmd_ready);
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_arg   = arg;
        bus.wrap_en   = wr;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    // Step cycles until done, counting enable cycles; bounded.
    task automatic run_until_done(output int ens, output int cyc);
        ens = 0;
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 200) begin
            if (bus.cnt_en === 1'b1) ens++;
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (bus.done !== 1'b1) begin
            n_fail++;
            $display("FAIL done_timeout: done=%0b required 1 within 200 cycles", bus.done);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: ready/busy/done=%0b%0b%0b required 100",
                     bus.cmd_ready, bus.busy, bus.done);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.cnt_load, bus.cnt_en, bus.cnt_dir, bus.sat, bus.aborted} !== 5'b0 ||
            bus.cnt_load_val !== 4'd0 || bus.steps_left !== 8'd0 || bus.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_outputs: load/en/dir/sat/abt=%b val=%0d steps=%0d ready=%0b required 00000 0 0 1",
                     {bus.cnt_load, bus.cnt_en, bus.cnt_dir, bus.sat, bus.aborted},
                     bus.cnt_load_val, bus.steps_left, bus.cmd_ready);
        end
    endtask

    task automatic test_load();
        issue(OP_LOAD, 8'd5, 1'b0);
        n_checks++;
        if (bus.cnt_load !== 1'b1 || bus.cnt_load_val !== 4'd5 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL load_strobe: load=%0b val=%0d done=%0b required 1 5 0",
                     bus.cnt_load, bus.cnt_load_val, bus.done);
        end
        @(negedge clk);
        n_checks++;
        if (bus.cnt_load !== 1'b0 || bus.done !== 1'b1 || bus.cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL load_done: load=%0b done=%0b ready=%0b required 0 1 0",
                     bus.cnt_load, bus.done, bus.cmd_ready);
        end
        @(negedge clk);
        n_checks++;
        if (bus.cmd_ready !== 1'b1 || cnt !== 4'd5 || bus.cnt_load_val !== 4'd5 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL load_after: ready=%0b count=%0d val=%0d done=%0b required 1 5 5 0",
                     bus.cmd_ready, cnt, bus.cnt_load_val, bus.done);
        end
    endtask

    task automatic test_run_up();
        int ens, cyc;
        issue(OP_UP, 8'd3, 1'b0);
        n_checks++;
        if (bus.cnt_en !== 1'b1 || bus.cnt_dir !== 1'b1 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL up_start: en=%0b dir=%0b busy=%0b required 1 1 1",
                     bus.cnt_en, bus.cnt_dir, bus.busy);
        end
        run_until_done(ens, cyc);
        n_checks++;
        if (ens != 3 || cyc != 3 || cnt !== 4'd8 || bus.sat !== 1'b0 || bus.steps_left !== 8'd0) begin
            n_fail++;
            $display("FAIL up3: ens=%0d cyc=%0d count=%0d sat=%0b steps=%0d required 3 3 8 0 0",
                     ens, cyc, cnt, bus.sat, bus.steps_left);
        end
        @(negedge clk);
        n_checks++;
        if (bus.cmd_ready !== 1'b1 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL up3_ready: ready=%0b done=%0b required 1 0", bus.cmd_ready, bus.done);
        end
    endtask

    task automatic test_saturate();
        int ens, cyc;
        issue(OP_UP, 8'd20, 1'b0);
        run_until_done(ens, cyc);
        n_checks++;
        if (ens != 7 || cyc != 8 || cnt !== 4'd15 || bus.sat !== 1'b1 || bus.steps_left !== 8'd13) begin
            n_fail++;
            $display("FAIL sat_up20: ens=%0d cyc=%0d count=%0d sat=%0b steps=%0d required 7 8 15 1 13",
                     ens, cyc, cnt, bus.sat, bus.steps_left);
        end
    endtask

    task automatic test_wrap_and_zero();
        int ens, cyc;
        issue(OP_LOAD, 8'd3, 1'b0);
        run_until_done(ens, cyc);
        issue(OP_DOWN, 8'd18, 1'b1);
        run_until_done(ens, cyc);
        n_checks++;
        if (ens != 18 || cyc != 18 || cnt !== 4'd1 || bus.sat !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_down18: ens=%0d cyc=%0d count=%0d sat=%0b required 18 18 1 0",
                     ens, cyc, cnt, bus.sat);
        end
        issue(OP_UP, 8'd0, 1'b0);
        n_checks++;
        if (bus.done !== 1'b1 || bus.cnt_en !== 1'b0 || cnt !== 4'd1 || bus.steps_left !== 8'd0) begin
            n_fail++;
            $display("FAIL up_zero: done=%0b en=%0b count=%0d steps=%0d required 1 0 1 0",
                     bus.done, bus.cnt_en, cnt, bus.steps_left);
        end
    endtask

    task automatic test_abort();
        int ens, cyc;
        int en_ok = 1;
        issue(OP_LOAD, 8'd12, 1'b0);
        run_until_done(ens, cyc);
        issue(OP_DOWN, 8'd10, 1'b0);
        repeat (4) begin
            if (bus.cnt_en !== 1'b1) en_ok = 0;
            @(negedge clk);
        end
        n_checks++;
        if (en_ok != 1) begin
            n_fail++;
            $display("FAIL abort_pre_en: enable gaps=%0d required 0", 1 - en_ok);
        end
        bus.abort = 1'b1;
        #1;
        n_checks++;
        if (bus.cnt_en !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_mask: en=%0b done=%0b required 0 0", bus.cnt_en, bus.done);
        end
        @(negedge clk);
        bus.abort = 1'b0;
        n_checks++;
        if (bus.done !== 1'b1 || bus.aborted !== 1'b1 || bus.steps_left !== 8'd6 ||
            cnt !== 4'd8 || bus.sat !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_done: done=%0b aborted=%0b steps=%0d count=%0d sat=%0b required 1 1 6 8 0",
                     bus.done, bus.aborted, bus.steps_left, cnt, bus.sat);
        end
        // Command presented during DONE must wait for IDLE.
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_LOAD;
        bus.cmd_arg   = 8'd2;
        @(negedge clk);
        n_checks++;
        if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.cnt_load !== 1'b0) begin
            n_fail++;
            $display("FAIL held_cmd_idle: ready=%0b busy=%0b load=%0b required 1 0 0",
                     bus.cmd_ready, bus.busy, bus.cnt_load);
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        n_checks++;
        if (bus.cnt_load !== 1'b1 || bus.cnt_load_val !== 4'd2 || bus.aborted !== 1'b0) begin
            n_fail++;
            $display("FAIL held_cmd_load: load=%0b val=%0d aborted=%0b required 1 2 0",
                     bus.cnt_load, bus.cnt_load_val, bus.aborted);
        end
        run_until_done(ens, cyc);
        n_checks++;
        if (cnt !== 4'd2) begin
            n_fail++;
            $display("FAIL held_cmd_count: count=%0d required 2", cnt);
        end
    endtask

    task automatic test_reset_mid_run();
        int ens, cyc;
        int done_seen = 0;
        issue(OP_UP, 8'd20, 1'b0);
        run_until_done(ens, cyc);
        n_checks++;
        if (ens != 13 || cnt !== 4'd15 || bus.sat !== 1'b1 || bus.steps_left !== 8'd7) begin
            n_fail++;
            $display("FAIL sat_from2: ens=%0d count=%0d sat=%0b steps=%0d required 13 15 1 7",
                     ens, cnt, bus.sat, bus.steps_left);
        end
        issue(OP_DOWN, 8'd10, 1'b1);
        @(negedge clk);
        n_checks++;
        if (bus.cnt_en !== 1'b1 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_active: en=%0b busy=%0b required 1 1", bus.cnt_en, bus.busy);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.cnt_en !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_reset: en=%0b busy=%0b done=%0b ready=%0b required 0 0 0 1",
                     bus.cnt_en, bus.busy, bus.done, bus.cmd_ready);
        end
        repeat (2) begin
            @(negedge clk);
            if (bus.done !== 1'b0) done_seen++;
        end
        reset = 1'b0;
        @(negedge clk);
        if (bus.done !== 1'b0) done_seen++;
        n_checks++;
        if (done_seen != 0 || bus.cmd_ready !== 1'b1 || bus.sat !== 1'b0 ||
            bus.aborted !== 1'b0 || bus.steps_left !== 8'd0 || bus.cnt_en !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset: done_cycles=%0d ready=%0b sat=%0b aborted=%0b steps=%0d en=%0b required 0 1 0 0 0 0",
                     done_seen, bus.cmd_ready, bus.sat, bus.aborted, bus.steps_left, bus.cnt_en);
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b11;
        bus.cmd_arg   = 8'd0;
        bus.wrap_en   = 1'b0;
        bus.abort     = 1'b0;
        test_reset();
        test_load();
        test_run_up();
        test_saturate();
        test_wrap_and_zero();
        test_abort();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
